// File: rtl/fc_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// fc_l2_port_arbiter : round-robin N_REQ:1 arbiter for the FC L2 TCDM port,
// with stall lock and in-order ID FIFO for response routing.
// Optional macro FC_L2_ARB_PERF_CNT_EN adds saturating per-requester grant
// counters.
// Revision 1.0
// ============================================================================
module fc_l2_port_arbiter #(
  parameter int N_REQ     = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*ADDR_W-1:0]   add_i,
  input  logic [N_REQ-1:0]          wen_i,
  input  logic [N_REQ*DATA_W-1:0]   wdata_i,
  input  logic [N_REQ*DATA_W/8-1:0] be_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [N_REQ-1:0]          r_valid_o,
  output logic [DATA_W-1:0]         r_rdata_o,
  output logic                      l2_req_o,
  output logic [ADDR_W-1:0]         l2_add_o,
  output logic                      l2_wen_o,
  output logic [DATA_W-1:0]         l2_wdata_o,
  output logic [DATA_W/8-1:0]       l2_be_o,
  input  logic                      l2_gnt_i,
  input  logic                      l2_r_valid_i,
  input  logic [DATA_W-1:0]         l2_r_rdata_i,
  input  logic                      clr_cnt_i,
  output logic                      busy_o,
  output logic                      err_o,
  output logic [N_REQ*CNT_W-1:0]    grant_cnt_o
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int OCC_W = $clog2(MAX_OUTST + 1);
  localparam int BE_W  = DATA_W / 8;

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             lock_q, lock_d;
  logic [ID_W-1:0]  lock_id_q, lock_id_d;
  logic             err_q, err_d;
  logic [ID_W-1:0]  fifo_q [MAX_OUTST];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  sel_id;
  logic [ID_W:0]    cand;
  logic             fifo_full;
  logic             fifo_empty;
  logic             handshake;
  logic             pop;

  // Smallest offset from rr_ptr wins: scan offsets high to low, last hit sticks.
  always_comb begin
    win_id = rr_ptr_q;
    cand   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (req_i[cand[ID_W-1:0]]) win_id = cand[ID_W-1:0];
    end
  end

  assign sel_id     = lock_q ? lock_id_q : win_id;
  assign fifo_full  = (occ_q == OCC_W'(MAX_OUTST));
  assign fifo_empty = (occ_q == '0);
  assign l2_req_o   = (lock_q | (|req_i)) & ~fifo_full;
  assign handshake  = l2_req_o & l2_gnt_i;
  assign pop        = l2_r_valid_i & ~fifo_empty;
  assign r_rdata_o  = l2_r_rdata_i;
  assign busy_o     = ~fifo_empty;
  assign err_o      = err_q;

  always_comb begin
    l2_add_o   = '0;
    l2_wen_o   = 1'b1;
    l2_wdata_o = '0;
    l2_be_o    = '0;
    gnt_o      = '0;
    r_valid_o  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_id == ID_W'(i)) begin
        l2_add_o   = add_i[i*ADDR_W +: ADDR_W];
        l2_wen_o   = wen_i[i];
        l2_wdata_o = wdata_i[i*DATA_W +: DATA_W];
        l2_be_o    = be_i[i*BE_W +: BE_W];
        gnt_o[i]   = handshake;
      end
      if (pop && (fifo_q[rd_ptr_q] == ID_W'(i))) r_valid_o[i] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    err_d     = err_q | (l2_r_valid_i & fifo_empty);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    if (handshake) begin
      rr_ptr_d = (sel_id == ID_W'(N_REQ - 1)) ? '0 : sel_id + ID_W'(1);
      lock_d   = 1'b0;
      wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTST - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end else if (l2_req_o) begin
      // Stalled request: pin the selection until the L2 grants it.
      lock_d    = 1'b1;
      lock_id_d = sel_id;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTST - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({handshake, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (handshake) fifo_q[wr_ptr_q] <= sel_id;
  end

`ifdef FC_L2_ARB_PERF_CNT_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clr_cnt_i) begin
        cnt_d = '0;
      end else if (gnt_o[i] && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end

    assign grant_cnt_o[i*CNT_W +: CNT_W] = cnt_q;
  end
`else
  logic unused_clr;
  assign unused_clr  = clr_cnt_i;
  assign grant_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fc_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fc_l2_port_arbiter : directed scenarios plus randomized traffic, checked
// every cycle against a queue-based behavioural model. Revision 1.0
// ============================================================================
module tb_fc_l2_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 4;
  localparam int CW = 16;
`ifdef FC_L2_ARB_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] add = '0;
  logic [N-1:0]    wen = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N*BW-1:0] be = '0;
  logic            l2_gnt = 1'b0;
  logic            l2_rvalid = 1'b0;
  logic [DW-1:0]   l2_rdata = '0;
  logic            clr = 1'b0;

  logic [N-1:0]    gnt_o, r_valid_o;
  logic [DW-1:0]   r_rdata_o, l2_wdata_o;
  logic            l2_req_o, l2_wen_o, busy_o, err_o;
  logic [AW-1:0]   l2_add_o;
  logic [BW-1:0]   l2_be_o;
  logic [N*CW-1:0] grant_cnt_o;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  fc_l2_port_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o),
    .l2_req_o(l2_req_o), .l2_add_o(l2_add_o), .l2_wen_o(l2_wen_o),
    .l2_wdata_o(l2_wdata_o), .l2_be_o(l2_be_o),
    .l2_gnt_i(l2_gnt), .l2_r_valid_i(l2_rvalid), .l2_r_rdata_i(l2_rdata),
    .clr_cnt_i(clr), .busy_o(busy_o), .err_o(err_o), .grant_cnt_o(grant_cnt_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: state here is "after the coming posedge".
  int m_rr = 0;
  bit m_lock = 0;
  int m_lock_id = 0;
  bit m_err = 0;
  bit m_valid = 0;
  int m_q[$];
  int m_cnt[N];

  always @(negedge clk) begin
    int sel;
    bit found, anyr, exp_req, hs, pop;
    logic [N-1:0] exp_gnt, exp_rv;
    logic [N*CW-1:0] exp_cnt;
    anyr  = |req;
    sel   = m_rr;
    found = 0;
    if (m_lock) sel = m_lock_id;
    else
      for (int k = 0; k < N; k++)
        if (!found && req[(m_rr + k) % N]) begin
          sel   = (m_rr + k) % N;
          found = 1;
        end
    exp_req = (m_lock || anyr) && (m_q.size() < MO);
    hs      = exp_req && l2_gnt;
    pop     = l2_rvalid && (m_q.size() > 0);
    exp_gnt = '0;
    exp_rv  = '0;
    if (hs)  exp_gnt[sel] = 1'b1;
    if (pop) exp_rv[m_q[0]] = 1'b1;
    for (int i = 0; i < N; i++) exp_cnt[i*CW +: CW] = CW'(m_cnt[i]);

    if (rst_n && m_valid) begin
      chk("m_l2_req", 64'(l2_req_o), 64'(exp_req));
      chk("m_gnt", 64'(gnt_o), 64'(exp_gnt));
      chk("m_r_valid", 64'(r_valid_o), 64'(exp_rv));
      chk("m_r_rdata", 64'(r_rdata_o), 64'(l2_rdata));
      chk("m_busy", 64'(busy_o), 64'(m_q.size() > 0));
      chk("m_err", 64'(err_o), 64'(m_err));
      chk("m_grant_cnt", 64'(grant_cnt_o), 64'(exp_cnt));
      if (m_lock || anyr) begin
        chk("m_l2_add", 64'(l2_add_o), 64'(add[sel*AW +: AW]));
        chk("m_l2_wen", 64'(l2_wen_o), 64'(wen[sel]));
        chk("m_l2_wdata", 64'(l2_wdata_o), 64'(wdata[sel*DW +: DW]));
        chk("m_l2_be", 64'(l2_be_o), 64'(be[sel*BW +: BW]));
      end
    end

    if (!rst_n) begin
      m_q.delete();
      m_rr = 0; m_lock = 0; m_lock_id = 0; m_err = 0; m_valid = 1;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      else if (l2_rvalid) m_err = 1;
      if (hs) begin
        m_q.push_back(sel);
        m_rr   = (sel + 1) % N;
        m_lock = 0;
        if (CNT_EN && m_cnt[sel] < (1 << CW) - 1) m_cnt[sel]++;
      end else if (exp_req) begin
        m_lock    = 1;
        m_lock_id = sel;
      end
      if (CNT_EN && clr) for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end
  end

  initial begin
    logic [N-1:0] g;
    add = {32'hC000_0002, 32'hB000_0001, 32'hA000_0000};
    wdata = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    chk("rst_l2_req", 64'(l2_req_o), 64'd0);
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_cnt", 64'(grant_cnt_o), 64'd0);

    // Fairness: 0,1,2,0,1,2 with a response each cycle after the first.
    req = 3'b111; l2_gnt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      l2_rvalid = (k > 0);
      l2_rdata  = DW'(k);
      #1;
      chk("fair_gnt", 64'(gnt_o), 64'(1 << (k % 3)));
      if (k > 0) chk("fair_rvalid", 64'(r_valid_o), 64'(1 << ((k - 1) % 3)));
      tick();
    end
    req = '0; l2_gnt = 1'b0; l2_rvalid = 1'b1;
    #1;
    chk("fair_cnt", 64'(grant_cnt_o), CNT_EN ? 64'h0002_0002_0002 : 64'd0);
    chk("fair_last_rvalid", 64'(r_valid_o), 64'b100);
    tick();
    l2_rvalid = 1'b0;
    #1;
    chk("fair_drained", 64'(busy_o), 64'd0);

    // Lock: requester 2 stalls, requester 0 arrives with higher priority.
    req = 3'b100;
    for (int k = 0; k < 3; k++) begin
      #1; chk("lock_add", 64'(l2_add_o), 64'hC000_0002);
      tick();
    end
    req = 3'b101;
    #1; chk("lock_add_hold", 64'(l2_add_o), 64'hC000_0002);
    tick();
    l2_gnt = 1'b1;
    #1; chk("lock_gnt", 64'(gnt_o), 64'b100);
    tick();
    req = 3'b001;
    #1; chk("lock_next_gnt", 64'(gnt_o), 64'b001);
    tick();
    req = '0; l2_gnt = 1'b0; l2_rvalid = 1'b1;
    #1; chk("lock_rv0", 64'(r_valid_o), 64'b100);
    tick();
    #1; chk("lock_rv1", 64'(r_valid_o), 64'b001);
    tick();
    l2_rvalid = 1'b0;

    // Routing: grants 1,0,2 then responses A,B,C.
    l2_gnt = 1'b1;
    req = 3'b010; #1; chk("route_g1", 64'(gnt_o), 64'b010); tick();
    req = 3'b001; #1; chk("route_g0", 64'(gnt_o), 64'b001); tick();
    req = 3'b100; #1; chk("route_g2", 64'(gnt_o), 64'b100); tick();
    req = '0; l2_gnt = 1'b0; l2_rvalid = 1'b1;
    l2_rdata = 32'hA; #1; chk("route_rv_a", 64'(r_valid_o), 64'b010);
    chk("route_data_a", 64'(r_rdata_o), 64'hA); tick();
    l2_rdata = 32'hB; #1; chk("route_rv_b", 64'(r_valid_o), 64'b001);
    chk("route_data_b", 64'(r_rdata_o), 64'hB); tick();
    l2_rdata = 32'hC; #1; chk("route_rv_c", 64'(r_valid_o), 64'b100);
    chk("route_data_c", 64'(r_rdata_o), 64'hC); tick();
    l2_rvalid = 1'b0;

    // Full: 4 outstanding stall the port until the cycle after a response.
    req = 3'b001; l2_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1; chk("full_fill_gnt", 64'(gnt_o), 64'b001); tick();
    end
    #1; chk("full_req", 64'(l2_req_o), 64'd0); chk("full_gnt", 64'(gnt_o), 64'd0);
    tick();
    l2_rvalid = 1'b1;
    #1; chk("full_pop_req", 64'(l2_req_o), 64'd0); chk("full_pop_gnt", 64'(gnt_o), 64'd0);
    chk("full_pop_rv", 64'(r_valid_o), 64'b001);
    tick();
    l2_rvalid = 1'b0;
    #1; chk("full_after_req", 64'(l2_req_o), 64'd1); chk("full_after_gnt", 64'(gnt_o), 64'b001);
    tick();
    req = '0; l2_gnt = 1'b0; l2_rvalid = 1'b1;
    repeat (4) tick();
    l2_rvalid = 1'b0;
    #1; chk("full_drained", 64'(busy_o), 64'd0);

    // Error: stray response with empty FIFO, sticky until reset.
    l2_rvalid = 1'b1;
    #1; chk("err_rv", 64'(r_valid_o), 64'd0); chk("err_pre", 64'(err_o), 64'd0);
    tick();
    l2_rvalid = 1'b0;
    #1; chk("err_set", 64'(err_o), 64'd1);
    repeat (3) tick();
    chk("err_sticky", 64'(err_o), 64'd1);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1; chk("err_cleared", 64'(err_o), 64'd0);

    // Randomized traffic with a mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g = gnt_o;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (g[i] || !req[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            req[i] = 1'b1;
            add[i*AW +: AW]   = $urandom;
            wen[i]            = 1'($urandom_range(0, 1));
            wdata[i*DW +: DW] = $urandom;
            be[i*BW +: BW]    = BW'($urandom_range(0, 15));
          end else begin
            req[i] = 1'b0;
          end
        end
      end
      l2_gnt    = ($urandom_range(0, 4) < 3);
      l2_rdata  = $urandom;
      l2_rvalid = (busy_o && $urandom_range(0, 1) == 1) || ($urandom_range(0, 299) == 0);
      clr       = ($urandom_range(0, 99) == 0);
      if (c == 1500) rst_n = 1'b0;
      if (c == 1502) rst_n = 1'b1;
    end
    req = '0; l2_gnt = 1'b0; l2_rvalid = 1'b0; clr = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
